// File: rtl/bit_serial_cmp_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
package bit_serial_cmp_ctrl_pkg;

    // Controller states: wait for a request, walk the bits, report for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bit_serial_cmp_ctrl_cmp_bit_cell.sv
// One-bit equality cell shared by every bit position of the serial walk.
// The output is forced low when the cell is not enabled, so a stale bit pair
// can never look like a match outside the scan.
module cmp_bit_cell (
    input  logic x,
    input  logic y,
    input  logic en,
    output logic match
);

    // Gated XNOR of the two operand bits.
    always_comb begin
        match = en & (x ~^ y);
    end

endmodule

// File: rtl/bit_serial_cmp_ctrl.sv
// Bit-serial unsigned comparator controller. Captures two operands on an
// accepted start, compares one bit pair per cycle from the MSB down, stops at
// the first difference, and holds a one-hot eq/gt/lt result until the next
// accepted start.
module bit_serial_cmp_ctrl
    import bit_serial_cmp_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    cmp_state_t       state;
    cmp_state_t       next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic             cell_en;
    logic             bit_match;

    cmp_bit_cell u_cell (
        .x     (a_reg[idx]),
        .y     (b_reg[idx]),
        .en    (cell_en),
        .match (bit_match)
    );

    // State register; reset returns to IDLE and abandons any scan in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status decode; leaving SCAN at idx 0 keeps idx from wrapping.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        cell_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                busy    = 1'b1;
                cell_en = 1'b1;
                if (!bit_match || (idx == '0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, bit index walk and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= IDX_TOP;
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!bit_match) begin
                        gt <= a_reg[idx];
                        lt <= b_reg[idx];
                    end else if (idx == '0) begin
                        eq <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_cmp_ctrl.sv
// Self-checking bench for bit_serial_cmp_ctrl: a WIDTH=4 instance driven from a
// vector table, hand-written corner sequences and random operands, plus a
// WIDTH=2 instance exercised with start held high.
module tb_bit_serial_cmp_ctrl;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] res;
        int         k;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       eq;
    logic       gt;
    logic       lt;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic       eq2;
    logic       gt2;
    logic       lt2;

    int tests;
    int failures;

    bit_serial_cmp_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    bit_serial_cmp_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .eq    (eq2),
        .gt    (gt2),
        .lt    (lt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it when it disagrees.
    task automatic checkOutput(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: one-hot {eq,gt,lt} from plain unsigned comparison.
    function automatic logic [2:0] refResult(input int av, input int bv);
        if (av == bv) return 3'b100;
        if (av > bv) return 3'b010;
        return 3'b001;
    endfunction

    // Reference: scan cycles = width minus position of the highest differing bit.
    function automatic int refCycles(input int av, input int bv, input int w);
        int x;
        x = av ^ bv;
        for (int i = w - 1; i >= 0; i--) begin
            if (((x >> i) & 1) == 1) return w - i;
        end
        return w;
    endfunction

    // Issue one start and follow the compare until done, with a cycle budget.
    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv,
                                 output int scan_cycles, output int done_seen,
                                 output logic [2:0] res, output int bad_busy,
                                 output int accepted);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        accepted = int'(busy);
        scan_cycles = 0;
        done_seen = 0;
        bad_busy = 0;
        res = 3'b000;
        for (int c = 0; c < 40; c++) begin
            if (busy) begin
                scan_cycles++;
                if (eq | gt | lt) bad_busy = 1;
            end
            if (done) begin
                done_seen = 1;
                res = {eq, gt, lt};
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t       vecs[8];
    int         sc;
    int         ds;
    int         bb;
    int         acc;
    int         pulses;
    int         last;
    int         bad;
    logic [2:0] r;
    logic [3:0] ra;
    logic [3:0] rb;

    initial begin
        tests = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        start2 = 1'b0;
        a2 = '0;
        b2 = '0;

        vecs[0] = '{4'b0101, 4'b0101, 3'b100, 4};
        vecs[1] = '{4'b1000, 4'b0111, 3'b010, 1};
        vecs[2] = '{4'b0110, 4'b0111, 3'b001, 4};
        vecs[3] = '{4'b0000, 4'b1111, 3'b001, 1};
        vecs[4] = '{4'b1111, 4'b1111, 3'b100, 4};
        vecs[5] = '{4'b1010, 4'b1000, 3'b010, 3};
        vecs[6] = '{4'b0100, 4'b0110, 3'b001, 3};
        vecs[7] = '{4'b0000, 4'b0000, 3'b100, 4};

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", int'({busy, done, eq, gt, lt}), 0);
        checkOutput("reset_outputs_w2", int'({busy2, done2, eq2, gt2, lt2}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, sc, ds, r, bb, acc);
            checkOutput($sformatf("vec%0d_accept", i), acc, 1);
            checkOutput($sformatf("vec%0d_done", i), ds, 1);
            checkOutput($sformatf("vec%0d_result", i), int'(r), int'(vecs[i].res));
            checkOutput($sformatf("vec%0d_scan_cycles", i), sc, vecs[i].k);
            checkOutput($sformatf("vec%0d_clear_while_busy", i), bb, 0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_width", i), int'(done), 0);
            checkOutput($sformatf("vec%0d_result_held", i), int'({eq, gt, lt}), int'(vecs[i].res));
        end

        // Inputs and start changing during SCAN must not disturb the compare.
        @(negedge clk);
        a = 4'b0011;
        b = 4'b0011;
        start = 1'b1;
        @(negedge clk);
        a = 4'b1111;
        b = 4'b0000;
        sc = 0;
        pulses = 0;
        r = 3'b000;
        for (int c = 0; c < 12; c++) begin
            if (busy) sc++;
            if (done) begin
                pulses++;
                r = {eq, gt, lt};
                start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("scan_change_result", int'(r), 3'b100);
        checkOutput("scan_change_cycles", sc, 4);
        checkOutput("scan_change_pulses", pulses, 1);

        // Reset during the second SCAN cycle aborts with no done pulse.
        @(negedge clk);
        a = 4'b0101;
        b = 4'b0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_outputs", int'({busy, done, eq, gt, lt}), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) bad = 1;
        end
        checkOutput("abort_no_done", bad, 0);
        applyStimulus(4'b0001, 4'b0000, sc, ds, r, bb, acc);
        checkOutput("post_abort_accept", acc, 1);
        checkOutput("post_abort_result", int'(r), 3'b010);
        checkOutput("post_abort_cycles", sc, 4);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = (i % 5 == 0) ? ra : 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, sc, ds, r, bb, acc);
            checkOutput($sformatf("rand%0d_a%0d_b%0d_result", i, ra, rb), int'(r),
                        int'(refResult(int'(ra), int'(rb))));
            checkOutput($sformatf("rand%0d_a%0d_b%0d_cycles", i, ra, rb), sc,
                        refCycles(int'(ra), int'(rb), 4));
            checkOutput($sformatf("rand%0d_clear_while_busy", i), bb, 0);
        end

        // WIDTH=2 with start held high: equal operands repeat every 4 cycles.
        @(negedge clk);
        a2 = 2'b01;
        b2 = 2'b01;
        start2 = 1'b1;
        pulses = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done2) begin
                pulses++;
                checkOutput("w2_eq_result", int'({eq2, gt2, lt2}), 3'b100);
                if (last >= 0) checkOutput("w2_eq_period", c - last, 4);
                last = c;
            end
        end
        checkOutput("w2_eq_pulses", pulses, 10);
        start2 = 1'b0;
        repeat (6) @(negedge clk);

        // WIDTH=2, MSB differs: one SCAN cycle, repeat every 3 cycles.
        a2 = 2'b10;
        b2 = 2'b01;
        start2 = 1'b1;
        pulses = 0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done2) begin
                pulses++;
                checkOutput("w2_gt_result", int'({eq2, gt2, lt2}), 3'b010);
                if (last >= 0) checkOutput("w2_gt_period", c - last, 3);
                last = c;
            end
        end
        checkOutput("w2_gt_pulses", pulses, 10);
        start2 = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_cmp_ctrl.md
BIT_SERIAL_CMP_CTRL -- requirements
Module: bit_serial_cmp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand width in bits, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a compare; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse in the DONE state.
REQ-009 The block SHALL have ports eq, gt and lt, outputs, 1 bit each: the result of A relative to B (unsigned), one-hot, held until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-011 In IDLE with start=1 at an edge, the block SHALL:
- capture a and b into internal registers;
- set the bit index to WIDTH-1;
- clear eq, gt and lt;
- go to SCAN.
REQ-012 In IDLE with start=0, the FSM SHALL remain in IDLE and all outputs SHALL hold.
REQ-013 In SCAN, each cycle SHALL compare exactly one bit pair (A[idx], B[idx]), MSB first, through a single shared 1-bit equality cell enabled only in SCAN.
REQ-014 On a mismatch at idx, the block SHALL:
- set gt=A[idx] and lt=B[idx];
- go to DONE on that edge (early termination).
REQ-015 On a match with idx=0, the block SHALL set eq=1 and go to DONE.
REQ-016 On a match with idx>0, the block SHALL decrement idx and stay in SCAN.
REQ-017 The block SHALL leave DONE unconditionally to IDLE after one cycle; done SHALL be high for exactly that cycle.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high in the cycle following edge N+k, where k = WIDTH - (index of the highest differing bit), or k = WIDTH when A==B. The minimum is 1 SCAN cycle; the maximum is WIDTH.
REQ-019 Changes on a, b or start during SCAN or DONE SHALL be ignored; start is not queued.
REQ-020 Exactly one of eq, gt and lt SHALL be 1 from the DONE cycle until the next accepted start; all three SHALL be 0 while busy=1.
REQ-021 The idx counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap below 0; the transition to DONE takes priority at idx=0.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL:
- go to IDLE;
- set busy=0, done=0, eq=0, gt=0 and lt=0;
- clear idx and the operand registers.
REQ-023 Reset SHALL take priority over start in the same cycle and SHALL abort a SCAN in progress with no done pulse.
REQ-024 After reset is released, the first start SHALL be accepted on the first edge where rst_n=1 and start=1.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, SCAN, DONE) and the default-width constant, 4.
REQ-026 The 1-bit equality cell SHALL be a separate sub-module, cmp_bit_cell (inputs x, y, en; output match).
REQ-027 When en=0, cmp_bit_cell SHALL output match=0.
REQ-028 The controller (FSM, idx counter, operand and result registers) SHALL be the top level only.

Verification
REQ-029 The bench SHALL cover an equal-operand compare: WIDTH=4, a=4'b0101, b=4'b0101, start for 1 cycle -> busy for 4 cycles, then done=1 with eq=1, gt=0, lt=0.
REQ-030 The bench SHALL cover an MSB early exit: a=4'b1000, b=4'b0111 -> done after 1 SCAN cycle with gt=1, eq=0, lt=0.
REQ-031 The bench SHALL cover an LSB difference: a=4'b0110, b=4'b0111 -> done after 4 SCAN cycles with lt=1.
REQ-032 The bench SHALL cover input changes during SCAN: start a=4'b0011, b=4'b0011, then during SCAN drive a=4'b1111, b=4'b0000 and start=1 -> result eq=1, one done pulse only, no restart.
REQ-033 The bench SHALL cover reset mid-operation: rst_n=0 during the 2nd SCAN cycle -> next cycle in IDLE, all outputs 0, no done; a new start with a=4'b0001, b=4'b0000 -> gt=1 after 4 SCAN cycles.
REQ-034 The bench SHALL cover the WIDTH boundary: WIDTH=2, back-to-back starts (start held high) -> every compare returns exactly one done pulse, separated by the single IDLE cycle in which the next start is accepted.
